// File: rtl/mac_alu_sequencer.sv
// Sequences UMLAL/SMLAL accumulation over the shared 32-bit ALU (ADD low, ADC high).
// Optional N/Z flag update request enabled by defining LEG_LMAC_FLAGS_EN.
module mac_alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        StartE,
    input  logic        AccumulateE,
    input  logic        SetFlagsE,
    input  logic        FlushE,
    input  logic [31:0] ProdLo,
    input  logic [31:0] ProdHi,
    input  logic [31:0] AccLo,
    input  logic [31:0] AccHi,
    input  logic [31:0] ALUResult,
    input  logic        ALUCarryOut,
    output logic        SeqOwnsALU,
    output logic        SeqALUOpE,
    output logic [3:0]  SeqALUControlE,
    output logic [31:0] SeqSrcA,
    output logic [31:0] SeqSrcB,
    output logic        SeqPrevC,
    output logic        StallSeq,
    output logic        DoneE,
    output logic        WriteLoE,
    output logic        WriteHiE,
    output logic [31:0] ResultLo,
    output logic [31:0] ResultHi,
    output logic        FlagWriteE,
    output logic        NFlag,
    output logic        ZFlag
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} seqState_t;

    seqState_t   stateQ, stateD;
    logic        carryQ, carryD;
    logic [31:0] resultLoQ, resultLoD;
    logic [31:0] resultHiQ, resultHiD;
    logic        accept;

`ifdef LEG_LMAC_FLAGS_EN
    logic        setFlagsQ, setFlagsD;
`else
    logic        unusedSetFlags;
    assign unusedSetFlags = SetFlagsE;
`endif

    assign accept = (stateQ == StIdle) && StartE && !FlushE;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= StIdle;
            carryQ    <= 1'b0;
            resultLoQ <= 32'd0;
            resultHiQ <= 32'd0;
`ifdef LEG_LMAC_FLAGS_EN
            setFlagsQ <= 1'b0;
`endif
        end else begin
            stateQ    <= stateD;
            carryQ    <= carryD;
            resultLoQ <= resultLoD;
            resultHiQ <= resultHiD;
`ifdef LEG_LMAC_FLAGS_EN
            setFlagsQ <= setFlagsD;
`endif
        end
    end

    // Next state; a flush in LO/HI abandons the op without touching the results.
    always_comb begin
        stateD    = stateQ;
        carryD    = carryQ;
        resultLoD = resultLoQ;
        resultHiD = resultHiQ;
`ifdef LEG_LMAC_FLAGS_EN
        setFlagsD = setFlagsQ;
`endif
        unique case (stateQ)
            StIdle: begin
                if (accept) begin
`ifdef LEG_LMAC_FLAGS_EN
                    setFlagsD = SetFlagsE;
`endif
                    if (AccumulateE) begin
                        stateD = StLo;
                    end else begin
                        stateD    = StDone;
                        resultLoD = ProdLo;
                        resultHiD = ProdHi;
                    end
                end
            end
            StLo: begin
                if (FlushE) begin
                    stateD = StIdle;
                end else begin
                    resultLoD = ALUResult;
                    carryD    = ALUCarryOut;
                    stateD    = StHi;
                end
            end
            StHi: begin
                if (FlushE) begin
                    stateD = StIdle;
                end else begin
                    resultHiD = ALUResult;
                    stateD    = StDone;
                end
            end
            StDone: stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        SeqOwnsALU     = 1'b0;
        SeqALUOpE      = 1'b0;
        SeqALUControlE = 4'b0000;
        SeqSrcA        = 32'd0;
        SeqSrcB        = 32'd0;
        SeqPrevC       = 1'b0;
        DoneE          = 1'b0;
        unique case (stateQ)
            StLo: begin
                SeqOwnsALU     = 1'b1;
                SeqALUOpE      = 1'b1;
                SeqALUControlE = 4'b0100;
                SeqSrcA        = ProdLo;
                SeqSrcB        = AccLo;
            end
            StHi: begin
                SeqOwnsALU     = 1'b1;
                SeqALUOpE      = 1'b1;
                SeqALUControlE = 4'b0101;
                SeqSrcA        = ProdHi;
                SeqSrcB        = AccHi;
                SeqPrevC       = carryQ;
            end
            StDone:  DoneE = !FlushE;
            default: ;
        endcase
    end

    assign StallSeq = accept || (stateQ == StLo) || (stateQ == StHi);
    assign WriteLoE = DoneE;
    assign WriteHiE = DoneE;
    assign ResultLo = resultLoQ;
    assign ResultHi = resultHiQ;

`ifdef LEG_LMAC_FLAGS_EN
    assign FlagWriteE = DoneE && setFlagsQ;
    assign NFlag      = FlagWriteE && resultHiQ[31];
    assign ZFlag      = FlagWriteE && (resultHiQ == 32'd0) && (resultLoQ == 32'd0);
`else
    assign FlagWriteE = 1'b0;
    assign NFlag      = 1'b0;
    assign ZFlag      = 1'b0;
`endif

endmodule

// File: tb/tb_mac_alu_sequencer.sv
// Directed bench for mac_alu_sequencer with a behavioural model of the shared ALU.
module tb_mac_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StartE = 1'b0, AccumulateE = 1'b0, SetFlagsE = 1'b0, FlushE = 1'b0;
    logic [31:0] ProdLo = '0, ProdHi = '0, AccLo = '0, AccHi = '0;
    logic [31:0] ALUResult;
    logic        ALUCarryOut;
    logic        SeqOwnsALU, SeqALUOpE, SeqPrevC, StallSeq;
    logic [3:0]  SeqALUControlE;
    logic [31:0] SeqSrcA, SeqSrcB, ResultLo, ResultHi;
    logic        DoneE, WriteLoE, WriteHiE, FlagWriteE, NFlag, ZFlag;

    int nTests = 0;
    int nFail  = 0;

`ifdef LEG_LMAC_FLAGS_EN
    localparam logic FlagsEn = 1'b1;
`else
    localparam logic FlagsEn = 1'b0;
`endif

    always #5 clk = ~clk;

    // Shared ALU: ADD, or ADC using SeqPrevC as carry-in.
    logic [32:0] aluSum;
    assign aluSum = {1'b0, SeqSrcA} + {1'b0, SeqSrcB}
                  + {32'd0, (SeqALUControlE == 4'b0101) && SeqPrevC};
    assign ALUResult   = aluSum[31:0];
    assign ALUCarryOut = aluSum[32];

    mac_alu_sequencer dut (
        .clk(clk), .reset(reset), .StartE(StartE), .AccumulateE(AccumulateE),
        .SetFlagsE(SetFlagsE), .FlushE(FlushE), .ProdLo(ProdLo), .ProdHi(ProdHi),
        .AccLo(AccLo), .AccHi(AccHi), .ALUResult(ALUResult), .ALUCarryOut(ALUCarryOut),
        .SeqOwnsALU(SeqOwnsALU), .SeqALUOpE(SeqALUOpE), .SeqALUControlE(SeqALUControlE),
        .SeqSrcA(SeqSrcA), .SeqSrcB(SeqSrcB), .SeqPrevC(SeqPrevC), .StallSeq(StallSeq),
        .DoneE(DoneE), .WriteLoE(WriteLoE), .WriteHiE(WriteHiE), .ResultLo(ResultLo),
        .ResultHi(ResultHi), .FlagWriteE(FlagWriteE), .NFlag(NFlag), .ZFlag(ZFlag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, ".own"}, {31'd0, SeqOwnsALU}, 32'd0);
        check({tag, ".ctl"}, {28'd0, SeqALUControlE}, 32'd0);
        check({tag, ".srcA"}, SeqSrcA, 32'd0);
        check({tag, ".done"}, {29'd0, DoneE, WriteLoE, WriteHiE}, 32'd0);
        check({tag, ".stall"}, {31'd0, StallSeq}, 32'd0);
        check({tag, ".flags"}, {29'd0, FlagWriteE, NFlag, ZFlag}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        checkIdleOutputs("rst");
        check("rst.resLo", ResultLo, 32'd0);
        check("rst.resHi", ResultHi, 32'd0);

        // UMLAL with carry out of the low word
        ProdHi = 32'h0000_0001; ProdLo = 32'hFFFF_FFFF;
        AccHi  = 32'h0000_0000; AccLo  = 32'h0000_0001;
        AccumulateE = 1'b1; StartE = 1'b1;
        #1;
        check("mlal.T.stall", {31'd0, StallSeq}, 32'd1);
        check("mlal.T.own", {31'd0, SeqOwnsALU}, 32'd0);
        tick();
        StartE = 1'b0;
        check("mlal.lo.own", {30'd0, SeqOwnsALU, SeqALUOpE}, 32'd3);
        check("mlal.lo.ctl", {28'd0, SeqALUControlE}, 32'h4);
        check("mlal.lo.srcA", SeqSrcA, 32'hFFFF_FFFF);
        check("mlal.lo.srcB", SeqSrcB, 32'd1);
        check("mlal.lo.prevC", {31'd0, SeqPrevC}, 32'd0);
        check("mlal.lo.stall", {31'd0, StallSeq}, 32'd1);
        tick();
        check("mlal.hi.ctl", {28'd0, SeqALUControlE}, 32'h5);
        check("mlal.hi.srcA", SeqSrcA, 32'd1);
        check("mlal.hi.srcB", SeqSrcB, 32'd0);
        check("mlal.hi.prevC", {31'd0, SeqPrevC}, 32'd1);
        check("mlal.hi.resLo", ResultLo, 32'd0);
        check("mlal.hi.done", {31'd0, DoneE}, 32'd0);
        tick();
        check("mlal.T3.done", {29'd0, DoneE, WriteLoE, WriteHiE}, 32'd7);
        check("mlal.T3.resHi", ResultHi, 32'd2);
        check("mlal.T3.resLo", ResultLo, 32'd0);
        check("mlal.T3.stall", {31'd0, StallSeq}, 32'd0);
        check("mlal.T3.own", {31'd0, SeqOwnsALU}, 32'd0);
        check("mlal.T3.flag", {31'd0, FlagWriteE}, 32'd0);
        tick();
        checkIdleOutputs("mlal.after");

        // UMULL: product only
        ProdHi = 32'h1234_5678; ProdLo = 32'h9ABC_DEF0;
        AccumulateE = 1'b0; StartE = 1'b1;
        #1;
        check("mull.T.own", {31'd0, SeqOwnsALU}, 32'd0);
        check("mull.T.stall", {31'd0, StallSeq}, 32'd1);
        tick();
        StartE = 1'b0;
        check("mull.T1.done", {29'd0, DoneE, WriteLoE, WriteHiE}, 32'd7);
        check("mull.T1.own", {31'd0, SeqOwnsALU}, 32'd0);
        check("mull.T1.resLo", ResultLo, 32'h9ABC_DEF0);
        check("mull.T1.resHi", ResultHi, 32'h1234_5678);
        tick();
        checkIdleOutputs("mull.after");

        // Flush while in HI
        ProdHi = 32'd0; ProdLo = 32'd5; AccHi = 32'd0; AccLo = 32'd7;
        AccumulateE = 1'b1; StartE = 1'b1;
        tick();
        StartE = 1'b0;
        tick();
        FlushE = 1'b1;
        #1;
        check("flushHi.done", {29'd0, DoneE, WriteLoE, WriteHiE}, 32'd0);
        tick();
        FlushE = 1'b0;
        #1;
        checkIdleOutputs("flushHi.next");
        check("flushHi.resLo", ResultLo, 32'd12);
        check("flushHi.resHi", ResultHi, 32'h1234_5678);
        tick();
        check("flushHi.noDone", {29'd0, DoneE, WriteLoE, WriteHiE}, 32'd0);

        // StartE held high: one op per trip through IDLE
        ProdLo = 32'd2; AccLo = 32'd3; StartE = 1'b1;
        tick();
        tick();
        check("hold.hi.done", {31'd0, DoneE}, 32'd0);
        tick();
        check("hold.done1", {31'd0, DoneE}, 32'd1);
        check("hold.done1.resLo", ResultLo, 32'd5);
        tick();
        check("hold.idle.done", {31'd0, DoneE}, 32'd0);
        check("hold.idle.own", {31'd0, SeqOwnsALU}, 32'd0);
        check("hold.idle.stall", {31'd0, StallSeq}, 32'd1);
        tick();
        StartE = 1'b0;
        check("hold.lo2.own", {31'd0, SeqOwnsALU}, 32'd1);
        tick();
        tick();
        check("hold.done2", {31'd0, DoneE}, 32'd1);
        tick();

        // Reset during LO
        StartE = 1'b1;
        tick();
        StartE = 1'b0;
        check("rstLo.own", {31'd0, SeqOwnsALU}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkIdleOutputs("rstLo");
        check("rstLo.resLo", ResultLo, 32'd0);
        check("rstLo.resHi", ResultHi, 32'd0);
        ProdHi = 32'hCAFE_0001; ProdLo = 32'h0000_BEEF; AccumulateE = 1'b0; StartE = 1'b1;
        tick();
        StartE = 1'b0;
        check("rstLo.new.done", {31'd0, DoneE}, 32'd1);
        check("rstLo.new.resHi", ResultHi, 32'hCAFE_0001);
        tick();

        // Flag requests: zero result, then negative result
        ProdHi = 32'd0; ProdLo = 32'd0; SetFlagsE = 1'b1; StartE = 1'b1;
        tick();
        StartE = 1'b0; SetFlagsE = 1'b0;
        check("flagZ", {29'd0, FlagWriteE, NFlag, ZFlag}, {29'd0, FlagsEn, 1'b0, FlagsEn});
        tick();
        check("flagZ.after", {29'd0, FlagWriteE, NFlag, ZFlag}, 32'd0);
        ProdHi = 32'h8000_0000; SetFlagsE = 1'b1; StartE = 1'b1;
        tick();
        StartE = 1'b0; SetFlagsE = 1'b0;
        check("flagN", {29'd0, FlagWriteE, NFlag, ZFlag}, {29'd0, FlagsEn, FlagsEn, 1'b0});
        tick();

        // Flush in DONE suppresses completion and flags
        ProdHi = 32'd0; SetFlagsE = 1'b1; StartE = 1'b1;
        tick();
        StartE = 1'b0; SetFlagsE = 1'b0; FlushE = 1'b1;
        #1;
        check("flushDone", {28'd0, DoneE, WriteLoE, WriteHiE, FlagWriteE}, 32'd0);
        tick();
        FlushE = 1'b0;
        #1;
        checkIdleOutputs("flushDone.next");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
